// File: rtl/sram_req_ctrl.sv
// Valid/ready request front end for a single-port SRAM macro with registered Q.
// Define SRAM_REQ_CTRL_INIT_EN to zero the array with a post-reset sweep.
module sram_req_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic              r_rd_inflight;
  logic              r_hold_v;
  logic [DATA_W-1:0] r_hold;
  logic              w_run;
  logic              w_acc;
  logic              w_sweep;
  logic [ADDR_W-1:0] w_sweep_addr;

`ifdef SRAM_REQ_CTRL_INIT_EN
  logic              r_init_done;
  logic [ADDR_W-1:0] r_init_addr;

  assign w_sweep      = reset_n && (r_state == ST_INIT);
  assign w_sweep_addr = r_init_addr;
  assign init_done    = r_init_done;
`else
  assign w_sweep      = 1'b0;
  assign w_sweep_addr = '0;
  assign init_done    = 1'b1;
`endif

  // Gating with reset_n keeps the pins and ready at their reset values while reset is held.
  assign w_run     = reset_n && (r_state == ST_RUN);
  assign req_ready = w_run && !r_hold_v && !(r_rd_inflight && !resp_ready);
  assign w_acc     = req_valid && req_ready;

  assign sram_ceb = !(w_acc || w_sweep);
  assign sram_web = w_sweep ? 1'b0 : !(w_acc && req_wen);
  assign sram_a   = w_sweep ? w_sweep_addr : (w_acc ? req_addr : '0);
  assign sram_d   = w_acc ? req_wdata : '0;

  assign resp_valid = r_hold_v || r_rd_inflight;
  assign resp_rdata = r_hold_v ? r_hold : (r_rd_inflight ? sram_q : '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
`ifdef SRAM_REQ_CTRL_INIT_EN
      r_state     <= ST_INIT;
      r_init_done <= 1'b0;
      r_init_addr <= '0;
`else
      r_state     <= ST_RUN;
`endif
      r_rd_inflight <= 1'b0;
      r_hold_v      <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_rd_inflight <= w_acc && !req_wen;
      // Q is only valid for one cycle, so a stalled response is parked in r_hold.
      if (r_rd_inflight && !resp_ready) begin
        r_hold   <= sram_q;
        r_hold_v <= 1'b1;
      end else if (r_hold_v && resp_ready) begin
        r_hold_v <= 1'b0;
      end
`ifdef SRAM_REQ_CTRL_INIT_EN
      if (r_state == ST_INIT) begin
        r_init_addr <= r_init_addr + ADDR_W'(1);
        if (r_init_addr == ADDR_W'(DEPTH - 1)) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: behavioural macro model, scoreboard,
// vector table and hand-written stall/reset sequences.
module tb_sram_req_ctrl;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wen = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  sram_req_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  always #5 clock = ~clock;

  // Macro model: registered Q, random Q on any cycle that is not a read.
  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  always @(posedge clock) begin
    if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web) sram_q <= mem[sram_a];
    else                       sram_q <= {$urandom, $urandom};
  end

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  bit mon_en = 1'b0;
  bit rand_rr = 1'b0;
  bit prev_rd = 1'b0;
  logic [DATA_W-1:0] sb [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops responses first, then records this cycle's handshake.
  always @(negedge clock) begin
    logic acc;
    logic [DATA_W-1:0] e;
    if (!reset_n) begin
      sb.delete();
      prev_rd = 1'b0;
    end else if (mon_en) begin
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        if (sb.size() == 0) chk("resp_unexpected", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("resp_data", resp_rdata, e);
        end
      end
      if (prev_rd) chk("read_latency", resp_valid, 1'b1);
      acc = req_valid && req_ready;
      chk("pin_ceb", sram_ceb, !acc);
      if (acc) begin
        chk("pin_web", sram_web, !req_wen);
        chk("pin_a", sram_a, req_addr);
        if (req_wen) chk("pin_d", sram_d, req_wdata);
      end else begin
        chk("idle_a_d", {sram_a, sram_d} == '0, 1'b1);
      end
      if (acc && req_wen) shadow[req_addr] = req_wdata;
      if (acc && !req_wen) sb.push_back(shadow[req_addr]);
      prev_rd = acc && !req_wen;
    end
  end

  task automatic tick();
    @(posedge clock); #2;
    if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Holds the request until accepted; returns at the start of the following cycle.
  task automatic send(input logic wen, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      tick();
      @(negedge clock);
      n++;
    end
    chk("send_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_ceb", sram_ceb, 1'b1);
    chk("rst_web", sram_web, 1'b1);
    chk("rst_a", sram_a, '0);
    chk("rst_d", sram_d, '0);
`ifdef SRAM_REQ_CTRL_INIT_EN
    chk("rst_init_done", init_done, 1'b0);
`else
    chk("rst_init_done", init_done, 1'b1);
`endif
  endtask

`ifdef SRAM_REQ_CTRL_INIT_EN
  // Called at the start of the first cycle after reset release.
  task automatic init_sweep(input int stop_at);
    int cyc = 0;
    while (cyc < 200) begin
      @(negedge clock);
      if (init_done) break;
      chk("sweep_req_ready", req_ready, 1'b0);
      chk("sweep_pins", {sram_ceb, sram_web, sram_a}, {2'b00, 7'(cyc)});
      chk("sweep_d", sram_d, '0);
      if (cyc == stop_at) return;
      @(posedge clock); #2;
      cyc++;
    end
    chk("init_cycles", 64'(cyc), 64'd128);
  endtask
`endif

  typedef struct packed {
    logic              v;
    logic              wen;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              rr;
    logic              exp_rdy;
    logic              exp_ceb;
    logic              exp_web;
    logic [ADDR_W-1:0] exp_a;
    logic              exp_rv;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];
  logic [DATA_W-1:0] va [4];
  int base;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {32'hA5A5_0000 | 32'(i), 32'h0F0F_0F0F ^ 32'(i * 3)};
`ifdef SRAM_REQ_CTRL_INIT_EN
      shadow[i] = '0;
`else
      shadow[i] = mem[i];
`endif
    end
    //           v     wen   a      d             rr    rdy   ceb   web   exp_a  rv
    tbl[0]  = '{1'b1, 1'b1, 7'd10, 64'h1111_0001, 1'b1, 1'b1, 1'b0, 1'b0, 7'd10, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 7'd11, 64'h2222_0002, 1'b1, 1'b1, 1'b0, 1'b0, 7'd11, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 7'd10, 64'h0,         1'b1, 1'b1, 1'b0, 1'b1, 7'd10, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 7'd11, 64'h0,         1'b1, 1'b1, 1'b0, 1'b1, 7'd11, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 7'd33, 64'h55,        1'b1, 1'b1, 1'b1, 1'b1, 7'd0,  1'b1};
    tbl[5]  = '{1'b0, 1'b0, 7'd0,  64'h0,         1'b1, 1'b1, 1'b1, 1'b1, 7'd0,  1'b0};
    tbl[6]  = '{1'b1, 1'b0, 7'd10, 64'h0,         1'b0, 1'b1, 1'b0, 1'b1, 7'd10, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 7'd0,  64'h0,         1'b0, 1'b0, 1'b1, 1'b1, 7'd0,  1'b1};
    tbl[8]  = '{1'b0, 1'b0, 7'd0,  64'h0,         1'b1, 1'b0, 1'b1, 1'b1, 7'd0,  1'b1};
    tbl[9]  = '{1'b1, 1'b0, 7'd11, 64'h0,         1'b1, 1'b1, 1'b0, 1'b1, 7'd11, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 7'd0,  64'h0,         1'b1, 1'b1, 1'b1, 1'b1, 7'd0,  1'b1};
    tbl[11] = '{1'b0, 1'b0, 7'd0,  64'h0,         1'b1, 1'b1, 1'b1, 1'b1, 7'd0,  1'b0};

    // Reset held with a read pending: pins must stay idle.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 7'd3;
    repeat (3) @(posedge clock);
    #2;
    chk_reset_vals();

`ifdef SRAM_REQ_CTRL_INIT_EN
    req_valid = 1'b0; req_addr = '0;
    reset_n = 1'b1;
    init_sweep(-1);
    @(posedge clock); #2;
    mon_en = 1'b1;
    send(1'b0, 7'd0, '0);
    send(1'b0, 7'd77, '0);
    send(1'b0, 7'd127, '0);
    idle(2);
    chk("init_reads_drained", 64'(sb.size()), 64'd0);
`else
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    chk("first_cycle_ready", req_ready, 1'b1);
    @(posedge clock); #2;
    req_valid = 1'b0; req_addr = '0;
    @(negedge clock);
    chk("first_resp_valid", resp_valid, 1'b1);
    chk("first_resp_data", resp_rdata, mem[3]);
    @(posedge clock); #2;
    idle(1);
`endif

    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].v; req_wen = tbl[i].wen; req_addr = tbl[i].a;
      req_wdata = tbl[i].d; resp_ready = tbl[i].rr;
      @(negedge clock);
      chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].exp_rdy);
      chk($sformatf("vec%0d_ceb_web", i), {sram_ceb, sram_web}, {tbl[i].exp_ceb, tbl[i].exp_web});
      chk($sformatf("vec%0d_a", i), sram_a, tbl[i].exp_a);
      chk($sformatf("vec%0d_resp_valid", i), resp_valid, tbl[i].exp_rv);
      @(posedge clock); #2;
    end
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    idle(1);

    // Write then read the same address on the next cycle.
    send(1'b1, 7'd5, 64'hDEAD_BEEF_CAFE_F00D);
    send(1'b0, 7'd5, '0);
    @(negedge clock);
    chk("wr_rd_resp_valid", resp_valid, 1'b1);
    chk("wr_rd_resp_data", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clock); #2;
    idle(1);

    // Stall: reads 1,2,3 with resp_ready low for 3 cycles from the first response.
    for (int i = 1; i <= 3; i++) begin
      va[i] = {$urandom, $urandom};
      send(1'b1, 7'(i), va[i]);
    end
    base = resp_cnt;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 7'd1;
    @(negedge clock);
    chk("stall_first_ready", req_ready, 1'b1);
    @(posedge clock); #2;
    req_addr = 7'd2;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("stall%0d_valid", i), resp_valid, 1'b1);
      chk($sformatf("stall%0d_data", i), resp_rdata, va[1]);
      chk($sformatf("stall%0d_ready", i), req_ready, 1'b0);
      @(posedge clock); #2;
    end
    resp_ready = 1'b1;
    @(negedge clock);
    chk("stall_release_data", resp_rdata, va[1]);
    chk("stall_release_bubble", req_ready, 1'b0);
    @(posedge clock); #2;
    send(1'b0, 7'd2, '0);
    send(1'b0, 7'd3, '0);
    idle(3);
    chk("stall_resp_count", 64'(resp_cnt - base), 64'd3);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Interleaved write/read of address 9 under random resp_ready.
    rand_rr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 7'd9, {$urandom, $urandom});
      send(1'b0, 7'd9, '0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    idle(4);
    chk("interleave_drained", 64'(sb.size()), 64'd0);

    // Reset while a response is held: it must be dropped.
    resp_ready = 1'b0;
    send(1'b0, 7'd9, '0);
    idle(1);
    chk("held_before_reset", resp_valid, 1'b1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    resp_ready = 1'b1;
    @(posedge clock); #2;

`ifdef SRAM_REQ_CTRL_INIT_EN
    reset_n = 1'b1;
    init_sweep(40);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clock); #2;
    reset_n = 1'b1;
    init_sweep(-1);
    @(posedge clock); #2;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    mon_en = 1'b1;
    send(1'b0, 7'd9, '0);
    send(1'b0, 7'd40, '0);
    idle(3);
`else
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    chk("post_reset_no_resp", resp_valid, 1'b0);
    @(posedge clock); #2;
    send(1'b0, 7'd9, '0);
    idle(3);
`endif
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
